rsa_modexp_decryptor: RTL and testbench
=======================================

Name: rsa_modexp_decryptor

Overview:
Handshaked RSA decryption engine computing decrypted = cipher^D mod N. It uses constant-time left-to-right square-and-multiply over a sequential modular multiplier. It is the receiving end of the encrypt path: it consumes ciphertext words with valid/ready and returns plaintext words with valid/ready. The fixed latency keeps the timing independent of the key bits.

Parameters:
WIDTH, 8, operand/modulus width in bits
N, 187, modulus (11*17); legal range 2 <= N < 2^WIDTH
D, 23, private exponent (pairs with public e=7); legal range D < 2^EXP_W
EXP_W, 8, exponent bits scanned, MSB first

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-low; same name as the rest of the codebase
in_valid  input  1  ciphertext word offered
in_ready  output  1  engine idle and able to accept
cipher  input  WIDTH  ciphertext; sampled when in_valid && in_ready
out_valid  output  1  result held valid
out_ready  input  1  consumer accepts result
decrypted  output  WIDTH  plaintext result
range_err  output  1  qualifies the current result; set when the accepted cipher >= N

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, out_valid=0, decrypted=0, range_err=0, accumulators cleared. Reset mid-operation aborts the computation with no output. in_ready is 1 from the first cycle after rst returns high.
- in_ready = (state==IDLE), decoded combinationally from the state register.
- FSM states: IDLE, LOAD, MUL, SQR, NEXT, DONE.
- IDLE: on in_valid, latch base=cipher, acc=1, bit index k=EXP_W-1.
  - If cipher >= N, go directly to DONE with decrypted=0 and range_err=1; out_valid rises on the next cycle.
- LOAD: one cycle; go to SQR.
- SQR: acc = acc*acc mod N via the sub-module. On done, go to MUL.
- MUL: always start tmp = acc*base mod N, for constant time. On done, acc = D[k] ? tmp : acc. Go to NEXT.
- NEXT: if k==0, go to DONE; else k-=1 and go to SQR.
- DONE: out_valid=1; decrypted and range_err stay stable until out_valid && out_ready. Then out_valid=0 and return to IDLE.
  - in_ready is 0 throughout DONE; no input is accepted while a result is pending.
  - Back-to-back operation: the earliest next accept is in the cycle after the output handshake.
- Latency for a valid cipher, from accept edge to out_valid high: exactly 2 + EXP_W*(2*(WIDTH+2)+1) cycles, which is 170 for the defaults. The out-of-range case takes exactly 1 cycle.
- Modular multiply (interleaved shift-add), r=0, for i = WIDTH-1 down to 0:
  - r = 2r; if r >= N then r -= N
  - if a[i], r = r + b; if r >= N then r -= N
  - Intermediates are WIDTH+1 bits, and every result is < N.
  - One bit per cycle; done pulses exactly WIDTH+2 cycles after start (1 setup cycle + WIDTH iterations + 1 result cycle).
- Boundary results: cipher=0 gives 0; cipher=1 gives 1; cipher=N-1 gives (N-1)^D mod N. D=0 gives 1 for any in-range cipher.
- out_ready may be high before out_valid; this is allowed and causes no effect until DONE.

Decomposition:
- rsa_pkg holds: default key constants (RSA_N=187, RSA_E=7, RSA_D=23), WIDTH default, and the FSM state enumeration/encoding. rsa_encrypt shares the key constants.
- The sub-module is rsa_modmul: WIDTH and N parameters; ports clk, rst, start, a, b, done, result. It is instantiated once and time-shared between SQR and MUL.

Test Plan:
- Reset then cipher=142 (encryption of 'A'=65 under e=7) with out_ready=1 -> decrypted=65, range_err=0, out_valid exactly 170 cycles after the accept edge.
- cipher=128 (2^7 mod 187) -> decrypted=2; cipher=0 -> 0; cipher=1 -> 1. Each result is checked with in_valid held high; in_ready must stay low from accept until the output handshake.
- cipher=200 (>= N) -> out_valid one cycle after accept, decrypted=0, range_err=1. A following cipher=142 then decrypts to 65 with range_err=0.
- Backpressure: out_ready=0 for 50 cycles after out_valid -> decrypted=65 stays stable and in_ready=0 throughout. Raising out_ready for one cycle -> out_valid drops and in_ready=1 next cycle.
- Reset mid-operation: drive rst=0 for 1 cycle 60 cycles after accepting cipher=142 -> out_valid=0, decrypted=0, and in_ready=1 after release. A new cipher=128 then returns 2 with the full 170-cycle latency.
- Round trip with the encryptor: for all 187 messages m in 0..186, feed rsa_encrypt output into this block -> decrypted == m for every m.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared RSA key constants and the decryptor FSM state encoding.
// The encryptor uses the same key pair, so the constants live here.
package rsa_pkg;

    localparam int unsigned RSA_WIDTH = 8;
    localparam int unsigned RSA_N     = 187;
    localparam int unsigned RSA_E     = 7;
    localparam int unsigned RSA_D     = 23;
    localparam int unsigned RSA_EXP_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SQR  = 3'd2,
        ST_MUL  = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } rsa_state_e;

endpackage

// File: rtl/rsa_modmul.sv
// Sequential modular multiplier: result = a*b mod N, one multiplier bit per cycle.
// done pulses WIDTH+2 cycles after start; operands must already be reduced below N.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = RSA_WIDTH,
    parameter int unsigned N     = RSA_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned      CW  = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] N_W = WIDTH'(N);
    localparam logic [WIDTH:0]   N_X = {1'b0, N_W};

    function automatic logic [WIDTH-1:0] reduce(input logic [WIDTH:0] x);
        reduce = WIDTH'((x >= N_X) ? (x - N_X) : x);
    endfunction

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d, done_q, done_d;
    logic [WIDTH-1:0] r_mid_s, r_new_s;
    logic [WIDTH:0]   r_sum_s;

    // One interleaved iteration: double-and-reduce, then conditional add-and-reduce.
    always_comb begin
        r_mid_s = reduce({r_q, 1'b0});
        if (a_q[WIDTH-1]) begin
            r_sum_s = {1'b0, r_mid_s} + {1'b0, b_q};
        end else begin
            r_sum_s = {1'b0, r_mid_s};
        end
        r_new_s = reduce(r_sum_s);
    end

    // Sequencing: setup on start, WIDTH iterations, then publish result with a done pulse.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (start) begin
            a_d   = a;
            b_d   = b;
            r_d   = '0;
            cnt_d = CW'(WIDTH);
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q != '0) begin
                r_d   = r_new_s;
                a_d   = a_q << 1;
                cnt_d = cnt_q - CW'(1);
            end else begin
                result_d = r_q;
                done_d   = 1'b1;
                run_d    = 1'b0;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Multiplier state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: rtl/rsa_modexp_decryptor.sv
// RSA decryption engine: decrypted = cipher^D mod N via constant-time square-and-multiply.
// Every key bit costs a square and a multiply, so latency does not depend on D.
module rsa_modexp_decryptor
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = RSA_WIDTH,
    parameter int unsigned N     = RSA_N,
    parameter int unsigned D     = RSA_D,
    parameter int unsigned EXP_W = RSA_EXP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] cipher,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] decrypted,
    output logic             range_err
);

    localparam int unsigned      KW     = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [EXP_W-1:0] D_BITS = EXP_W'(D);
    localparam logic [WIDTH-1:0] N_W    = WIDTH'(N);

    rsa_state_e       state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d, acc_q, acc_d, dec_q, dec_d;
    logic [KW-1:0]    k_q, k_d;
    logic             rerr_q, rerr_d, out_valid_q, out_valid_d;
    logic             mm_start_s, mm_done_s;
    logic [WIDTH-1:0] mm_a_s, mm_b_s, mm_result_s;

    rsa_modmul #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_modmul (
        .clk    (clk),
        .rst    (rst),
        .start  (mm_start_s),
        .a      (mm_a_s),
        .b      (mm_b_s),
        .done   (mm_done_s),
        .result (mm_result_s)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            dec_q       <= '0;
            rerr_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            dec_q       <= dec_d;
            rerr_q      <= rerr_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        acc_d       = acc_q;
        k_d         = k_q;
        dec_d       = dec_q;
        rerr_d      = rerr_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    base_d = cipher;
                    acc_d  = WIDTH'(1);
                    k_d    = KW'(EXP_W - 1);
                    if (cipher >= N_W) begin
                        state_d = ST_DONE;
                        dec_d   = '0;
                        rerr_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: state_d = ST_SQR;
            ST_SQR: begin
                if (mm_done_s) begin
                    acc_d   = mm_result_s;
                    state_d = ST_MUL;
                end else begin
                    state_d = ST_SQR;
                end
            end
            ST_MUL: begin
                if (mm_done_s) begin
                    acc_d   = D_BITS[k_q] ? mm_result_s : acc_q;
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_NEXT: begin
                if (k_q == KW'(0)) begin
                    state_d = ST_DONE;
                    dec_d   = acc_q;
                    rerr_d  = 1'b0;
                end else begin
                    k_d     = k_q - KW'(1);
                    state_d = ST_SQR;
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Multiplier launches are issued one cycle ahead so SQR and MUL each last WIDTH+2 cycles.
    always_comb begin
        in_ready   = (state_q == ST_IDLE);
        mm_start_s = 1'b0;
        mm_a_s     = acc_q;
        mm_b_s     = acc_q;
        case (state_q)
            ST_LOAD: mm_start_s = 1'b1;
            ST_NEXT: mm_start_s = (k_q != KW'(0));
            ST_SQR: begin
                mm_start_s = mm_done_s;
                mm_a_s     = mm_result_s;
                mm_b_s     = base_q;
            end
            default: mm_start_s = 1'b0;
        endcase
    end

    assign out_valid = out_valid_q;
    assign decrypted = dec_q;
    assign range_err = rerr_q;

endmodule

// File: tb/tb_rsa_modexp_decryptor.sv
// Scoreboard bench for rsa_modexp_decryptor: driver pushes expected results,
// a monitor pops and compares on every output handshake.
module tb_rsa_modexp_decryptor;
    import rsa_pkg::*;

    localparam int unsigned W   = RSA_WIDTH;
    localparam int unsigned NM  = RSA_N;
    localparam int unsigned DK  = RSA_D;
    localparam int unsigned EW  = RSA_EXP_W;
    localparam int unsigned LAT = 2 + EW * (2 * (W + 2) + 1);

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, range_err;
    logic [W-1:0] cipher, decrypted;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    typedef struct {
        int unsigned dec;
        bit          rerr;
        int unsigned lat;
        int unsigned acc_edge;
    } exp_t;

    exp_t sb[$];

    bit           prev_ov   = 1'b0;
    logic [W-1:0] prev_dec  = '0;
    logic         prev_rerr = 1'b0;

    rsa_modexp_decryptor dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cipher    (cipher),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .decrypted (decrypted),
        .range_err (range_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int unsigned modpow(input int unsigned b, input int unsigned e,
                                           input int unsigned m);
        int unsigned r = 1 % m;
        for (int i = 0; i < int'(e); i++) r = (r * (b % m)) % m;
        return r;
    endfunction

    // Offer a cipher; once accepted, push the expectation and keep in_valid high.
    task automatic issue(input int unsigned c, input int unsigned exp_dec,
                         input bit exp_rerr, input int unsigned lat);
        exp_t e;
        int   n = 0;
        cipher   = W'(c);
        in_valid = 1'b1;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            e.dec      = exp_dec;
            e.rerr     = exp_rerr;
            e.lat      = lat;
            e.acc_edge = cyc + 1;
            sb.push_back(e);
            @(negedge clk);
        end
    endtask

    // Wait for the scoreboard to drain, optionally jittering out_ready.
    task automatic wait_empty(input bit rnd);
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sb.size() != 0) begin
            chk("result_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    // Monitor: samples just after the falling edge, after the driver has settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b1) begin
                if (out_valid && !prev_ov) begin
                    if (sb.size() == 0) chk("spurious_valid", {31'd0, out_valid}, 32'd0);
                    else chk("latency", cyc - sb[0].acc_edge, sb[0].lat);
                end
                if (sb.size() != 0 && cyc >= sb[0].acc_edge)
                    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
                if (out_valid && prev_ov) begin
                    chk("hold_decrypted", decrypted, prev_dec);
                    chk("hold_range_err", {31'd0, range_err}, {31'd0, prev_rerr});
                end
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("decrypted", decrypted, e.dec);
                    chk("range_err", {31'd0, range_err}, {31'd0, e.rerr});
                end
            end
            prev_ov   = out_valid;
            prev_dec  = decrypted;
            prev_rerr = range_err;
        end
    end

    initial begin
        int unsigned c;
        int          n;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cipher    = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_decrypted", decrypted, 32'd0);
        chk("rst_range_err", {31'd0, range_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        issue(142, 65, 1'b0, LAT);  wait_empty(1'b0);
        issue(128, 2, 1'b0, LAT);   wait_empty(1'b0);
        issue(0, 0, 1'b0, LAT);     wait_empty(1'b0);
        issue(1, 1, 1'b0, LAT);     wait_empty(1'b0);
        issue(NM - 1, modpow(NM - 1, DK, NM), 1'b0, LAT); wait_empty(1'b0);
        issue(200, 0, 1'b1, 1);     wait_empty(1'b0);
        issue(142, 65, 1'b0, LAT);  wait_empty(1'b0);
        issue(NM, 0, 1'b1, 1);      wait_empty(1'b0);

        // Backpressure: hold the result for 50 cycles, then release for one cycle.
        out_ready = 1'b0;
        issue(142, 65, 1'b0, LAT);
        n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        repeat (50) @(negedge clk);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_decrypted", decrypted, 32'd65);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        wait_empty(1'b0);

        // Reset during a computation aborts it without producing a result.
        issue(142, 65, 1'b0, LAT);
        repeat (59) @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_decrypted", decrypted, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (5) @(negedge clk);
        issue(128, 2, 1'b0, LAT);   wait_empty(1'b0);

        // Randomized ciphers, including out-of-range ones, with jittered out_ready.
        for (int i = 0; i < 12; i++) begin
            c = $urandom_range(0, (1 << W) - 1);
            if (c >= NM) issue(c, 0, 1'b1, 1);
            else issue(c, modpow(c, DK, NM), 1'b0, LAT);
            wait_empty(1'b1);
        end

        // Round trip: every message encrypted with the public exponent must come back.
        for (int m = 0; m < int'(NM); m++) begin
            issue(modpow(m, RSA_E, NM), m, 1'b0, LAT);
            wait_empty(1'b0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
